// File: rtl/rca_multiword_seq.sv
// Wide (N*WORDS-bit) adder built by stepping one N-bit ripple-carry slice
// across the operand words, with the inter-slice carry held in a register.

module ripple_carry_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[N];

endmodule

module rca_multiword_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [N-1:0]     slice_sum;
  logic             slice_cout;

  ripple_carry_adder #(.N(N)) u_slice (
    .A    (a_q[idx_q*N +: N]),
    .B    (b_q[idx_q*N +: N]),
    .Cin  (carry_q),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*N +: N] = slice_sum;
        carry_d             = slice_cout;
        if (idx_q == LAST_IDX) begin
          // Overflow only when both operands share a sign that the result lost.
          cout_d  = slice_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[N-1] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_multiword_seq.sv
// Directed and random checks of rca_multiword_seq against a plain-arithmetic
// model of a W-bit two's-complement add.

module tb_rca_multiword_seq;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  rca_multiword_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("accept_in_ready", 32'(in_ready), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] ta,
                           input logic [W-1:0] tb, input logic tc);
    logic [W:0]   full;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    full     = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    exp_ovf  = (ta[W-1] == tb[W-1]) && (exp_sum[W-1] != ta[W-1]);
    for (int k = 1; k <= WORDS; k++) begin
      step();
      check({tag, "_out_valid_timing"}, 32'(out_valid), (k == WORDS) ? 32'd1 : 32'd0);
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    end
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_release_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input logic tc);
    start_op(ta, tb, tc);
    finish_op(tag, ta, tb, tc);
    release_result(tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    step();
    step();
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'h0000);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    full_op("basic", 16'h0001, 16'h0002, 1'b0);
    full_op("ripple_all_ones", 16'hFFFF, 16'hFFFF, 1'b1);
    full_op("ripple_cross", 16'hFFFF, 16'h0000, 1'b1);
    full_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
    full_op("ovf_neg", 16'h8000, 16'h8000, 1'b0);

    // Backpressure: result must hold and in_valid must be ignored in DONE.
    start_op(16'h1234, 16'h1111, 1'b0);
    finish_op("bp", 16'h1234, 16'h1111, 1'b0);
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      step();
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h2345);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_sum_kept", 32'(sum), 32'h2345);
    step();
    in_valid = 1'b0;
    check("bp_next_accept_busy", 32'(busy), 32'd1);
    finish_op("bp_next", 16'hAAAA, 16'h5555, 1'b1);
    release_result("bp_next");

    // Reset two RUN edges into an operation: back to IDLE with cleared result.
    start_op(16'h0F0F, 16'h0101, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'h0000);
    for (int k = 0; k < WORDS + 1; k++) begin
      step();
      check("midrst_no_out_valid", 32'(out_valid), 32'd0);
    end
    full_op("after_rst", 16'h1234, 16'h4321, 1'b0);

    // Reset together with in_valid must not accept the operand.
    a        = 16'h1111;
    b        = 16'h2222;
    in_valid = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid_in_ready", 32'(in_ready), 32'd1);
    check("rst_vs_valid_busy", 32'(busy), 32'd0);

    for (int t = 0; t < 20; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      full_op("random", ra, rb, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
